// File: rtl/lookup_table_mp_if.sv
// Bus bundle for lookup_table_mp: single writer, clear request and NRD packed read ports.
// master = configuration/consumer side, slave = the table itself.
interface lookup_table_mp_if #(
    parameter int unsigned ASIZE  = 4,
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned NRD    = 2
);
    logic                    clr_req;
    logic                    busy;
    logic                    wr_en;
    logic [ASIZE-1:0]        wr_addr;
    logic [DWIDTH-1:0]       wr_data;
    logic [NRD-1:0]          rd_en;
    logic [NRD*ASIZE-1:0]    rd_addr;
    logic [NRD*DWIDTH-1:0]   rd_data;
    logic [NRD-1:0]          rd_valid;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/lookup_table_mp.sv
// Clocked multi-read-port lookup table with a clear sequencer that sweeps INIT_VAL into
// every entry after reset or on request, registered reads and write-first bypass.
module lookup_table_mp #(
    parameter int unsigned       ASIZE    = 4,
    parameter int unsigned       DWIDTH   = 8,
    parameter int unsigned       NRD      = 2,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    lookup_table_mp_if.slave  bus
);
    localparam int unsigned ARANGE = 1 << ASIZE;

    typedef enum logic {StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic [ASIZE-1:0]        cnt_q, cnt_d;
    logic [NRD*DWIDTH-1:0]   rd_data_q, rd_data_d;
    logic [NRD-1:0]          rd_valid_q, rd_valid_d;
    logic [DWIDTH-1:0]       mem_q [ARANGE];

    logic                    mem_we;
    logic [ASIZE-1:0]        mem_waddr;
    logic [DWIDTH-1:0]       mem_wdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = bus.wr_data;

        unique case (state_q)
            StClear: begin
                // Bus writes/reads/clears are ignored while sweeping.
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == {ASIZE{1'b1}}) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                mem_we = bus.wr_en;
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
                for (int i = 0; i < NRD; i++) begin
                    if (bus.rd_en[i]) begin
                        rd_valid_d[i] = 1'b1;
                        // Write-first: a same-cycle write to this address wins over old data.
                        if (bus.wr_en && (bus.rd_addr[i*ASIZE +: ASIZE] == bus.wr_addr)) begin
                            rd_data_d[i*DWIDTH +: DWIDTH] = bus.wr_data;
                        end else begin
                            rd_data_d[i*DWIDTH +: DWIDTH] = mem_q[bus.rd_addr[i*ASIZE +: ASIZE]];
                        end
                    end
                end
            end
            default: begin
                state_d = StClear;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is initialised by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.busy     = (state_q == StClear);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lookup_table_mp.sv
// Bench for lookup_table_mp: two configurations (default and 6/32/4/DEADBEEF) driven one at a
// time from shared stimulus, checked every cycle against a behavioural table model.
module tb_lookup_table_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, sized for the larger configuration.
    bit          sel = 1'b0;
    logic        rst_s = 1'b1;
    logic        clr_s = 1'b0;
    logic        wr_en_s = 1'b0;
    logic [5:0]  wr_addr_s = '0;
    logic [31:0] wr_data_s = '0;
    logic [3:0]  rd_en_s = '0;
    logic [5:0]  rd_addr_s [4];

    logic        busy_o;
    logic [3:0]  rd_valid_o;
    logic [31:0] rd_data_o [4];

    logic rst_a, rst_b;
    assign rst_a = sel ? 1'b1 : rst_s;
    assign rst_b = sel ? rst_s : 1'b1;

    lookup_table_mp_if #(.ASIZE(4), .DWIDTH(8), .NRD(2)) a_if ();
    lookup_table_mp_if #(.ASIZE(6), .DWIDTH(32), .NRD(4)) b_if ();

    lookup_table_mp #(.ASIZE(4), .DWIDTH(8), .NRD(2), .INIT_VAL(8'h00)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (a_if)
    );

    lookup_table_mp #(.ASIZE(6), .DWIDTH(32), .NRD(4), .INIT_VAL(32'hDEADBEEF)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (b_if)
    );

    assign a_if.clr_req = clr_s;
    assign a_if.wr_en   = wr_en_s;
    assign a_if.wr_addr = wr_addr_s[3:0];
    assign a_if.wr_data = wr_data_s[7:0];
    assign a_if.rd_en   = rd_en_s[1:0];
    assign b_if.clr_req = clr_s;
    assign b_if.wr_en   = wr_en_s;
    assign b_if.wr_addr = wr_addr_s;
    assign b_if.wr_data = wr_data_s;
    assign b_if.rd_en   = rd_en_s;

    always_comb begin
        a_if.rd_addr = '0;
        b_if.rd_addr = '0;
        for (int i = 0; i < 2; i++) a_if.rd_addr[i*4 +: 4] = rd_addr_s[i][3:0];
        for (int i = 0; i < 4; i++) b_if.rd_addr[i*6 +: 6] = rd_addr_s[i];
    end

    always_comb begin
        busy_o     = sel ? b_if.busy : a_if.busy;
        rd_valid_o = sel ? b_if.rd_valid : {2'b00, a_if.rd_valid};
        for (int i = 0; i < 4; i++) rd_data_o[i] = b_if.rd_data[i*32 +: 32];
        if (!sel) begin
            rd_data_o[2] = '0;
            rd_data_o[3] = '0;
            for (int i = 0; i < 2; i++) rd_data_o[i] = {24'h0, a_if.rd_data[i*8 +: 8]};
        end
    end

    // Active-configuration constants for the model.
    int unsigned nrd, arange;
    logic [5:0]  amask;
    logic [31:0] dmask, init_v;
    always_comb begin
        nrd    = sel ? 4 : 2;
        arange = sel ? 64 : 16;
        amask  = sel ? 6'h3f : 6'h0f;
        dmask  = sel ? 32'hFFFF_FFFF : 32'h0000_00FF;
        init_v = sel ? 32'hDEAD_BEEF : 32'h0;
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a table that becomes all-INIT once a full sweep has elapsed.
    bit          live = 1'b0;
    int unsigned sweep_left = 0;
    logic [31:0] mmem [64];
    logic        exp_v [4];
    logic [31:0] exp_d [4];

    always @(posedge clk) begin
        if (rst_s) begin
            live       <= 1'b1;
            sweep_left <= arange;
            for (int i = 0; i < 4; i++) begin
                exp_v[i] <= 1'b0;
                exp_d[i] <= '0;
            end
        end else if (live) begin
            if (sweep_left != 0) begin
                for (int i = 0; i < 4; i++) exp_v[i] <= 1'b0;
                sweep_left <= sweep_left - 1;
                if (sweep_left == 1) for (int a = 0; a < 64; a++) mmem[a] <= init_v;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (i < nrd && rd_en_s[i]) begin
                        exp_v[i] <= 1'b1;
                        exp_d[i] <= (wr_en_s && ((wr_addr_s & amask) == (rd_addr_s[i] & amask)))
                                    ? (wr_data_s & dmask) : mmem[rd_addr_s[i] & amask];
                    end else begin
                        exp_v[i] <= 1'b0;
                    end
                end
                if (wr_en_s) mmem[wr_addr_s & amask] <= wr_data_s & dmask;
                if (clr_s) sweep_left <= arange;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("busy", {31'b0, busy_o}, {31'b0, sweep_left != 0});
            for (int i = 0; i < 4; i++) begin
                if (i < nrd) begin
                    chk($sformatf("rd_valid[%0d]", i), {31'b0, rd_valid_o[i]}, {31'b0, exp_v[i]});
                    chk($sformatf("rd_data[%0d]", i), rd_data_o[i], exp_d[i]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wr_en_s   = 1'b1;
        wr_addr_s = a;
        wr_data_s = d;
        step();
        wr_en_s = 1'b0;
    endtask

    task automatic rd1(input int p, input logic [5:0] a);
        rd_en_s      = '0;
        rd_en_s[p]   = 1'b1;
        rd_addr_s[p] = a;
        step();
        rd_en_s = '0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic reset_init(input bit new_sel, input string tag);
        int n;
        rst_s = 1'b1;
        step();
        sel = new_sel;
        step();
        rst_s = 1'b0;
        count_busy(n);
        chk({tag, " init busy cycles"}, n, arange);
        for (int a = 0; a < int'(arange); a++) begin
            rd1(0, 6'(a));
            chk({tag, " init read"}, rd_data_o[0], init_v);
            chk({tag, " init valid"}, {31'b0, rd_valid_o[0]}, 32'd1);
        end
    endtask

    task automatic basic(input string tag);
        int last;
        last = int'(nrd) - 1;
        wr(6'd3, 32'h0000_00A5);
        rd1(0, 6'd3);
        chk({tag, " latency data"}, rd_data_o[0], 32'hA5);
        chk({tag, " latency valid"}, {31'b0, rd_valid_o[0]}, 32'd1);
        step();
        chk({tag, " hold valid"}, {31'b0, rd_valid_o[0]}, 32'd0);
        chk({tag, " hold data"}, rd_data_o[0], 32'hA5);
        wr(6'd7, 32'h11);
        wr_en_s   = 1'b1;
        wr_addr_s = 6'd7;
        wr_data_s = 32'h22;
        for (int i = 0; i < 4; i++) rd_addr_s[i] = 6'd7;
        rd_en_s = 4'hF;
        step();
        wr_en_s = 1'b0;
        rd_en_s = '0;
        for (int i = 0; i < int'(nrd); i++)
            chk($sformatf("%s bypass port %0d", tag, i), rd_data_o[i], 32'h22);
        chk({tag, " bypass valid"}, {28'b0, rd_valid_o}, sel ? 32'hF : 32'h3);
        // Distinct addresses on first and last port to pin the packing.
        wr(6'd9, 32'h1234_5678);
        rd_addr_s[0]    = 6'd3;
        rd_addr_s[last] = 6'd9;
        rd_en_s         = '0;
        rd_en_s[0]      = 1'b1;
        rd_en_s[last]   = 1'b1;
        step();
        rd_en_s = '0;
        chk({tag, " pack port0"}, rd_data_o[0], 32'hA5);
        chk({tag, " pack last"}, rd_data_o[last], 32'h1234_5678 & dmask);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) rd_addr_s[i] = '0;

        reset_init(1'b0, "A");
        basic("A");

        // Clear request with bus activity during the sweep.
        for (int a = 0; a < 16; a++) wr(6'(a), 32'h10 + a);
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        wr_en_s   = 1'b1;
        wr_addr_s = 6'd5;
        wr_data_s = 32'hFF;
        rd_en_s   = 4'h3;
        rd_addr_s[0] = 6'd5;
        rd_addr_s[1] = 6'd15;
        step();
        wr_en_s = 1'b0;
        rd_en_s = '0;
        chk("A valid in clear", {28'b0, rd_valid_o}, 32'd0);
        count_busy(n);
        chk("A clear busy cycles", n + 1, 16);
        rd1(0, 6'd5);
        chk("A clear addr5", rd_data_o[0], 32'h0);
        rd1(1, 6'd15);
        chk("A clear addr15", rd_data_o[1], 32'h0);

        // Reset eight cycles into a sweep.
        wr(6'd2, 32'h55);
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        repeat (8) step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        count_busy(n);
        chk("A midsweep busy cycles", n, 16);
        for (int a = 0; a < 16; a++) begin
            rd1(a % 2, 6'(a));
            chk("A midsweep read", rd_data_o[a % 2], 32'h0);
        end

        reset_init(1'b1, "B");
        basic("B");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
